// File: rtl/fetch_controller_if.sv
// fetch_controller_if: PC control, program memory and decoder handshake signals; master = fetch_controller, slave = environment
interface fetch_controller_if #(parameter int INSTR_WIDTH = 16);
  logic [15:0] CounterValue;
  logic [15:0] PcLoadValue;
  logic PcLoadEnable;
  logic signed [8:0] PcOffset;
  logic PcOffsetEnable;
  logic [15:0] MemAddress;
  logic MemRead;
  logic [INSTR_WIDTH-1:0] MemData;
  logic [INSTR_WIDTH-1:0] Instruction;
  logic InstrValid;
  logic InstrReady;
  logic BranchTaken;
  logic signed [8:0] BranchOffset;
  logic JumpTaken;
  logic [15:0] JumpTarget;
  modport master (
    input CounterValue, MemData, InstrReady, BranchTaken, BranchOffset, JumpTaken, JumpTarget,
    output PcLoadValue, PcLoadEnable, PcOffset, PcOffsetEnable, MemAddress, MemRead, Instruction, InstrValid
  );
  modport slave (
    output CounterValue, MemData, InstrReady, BranchTaken, BranchOffset, JumpTaken, JumpTarget,
    input PcLoadValue, PcLoadEnable, PcOffset, PcOffsetEnable, MemAddress, MemRead, Instruction, InstrValid
  );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: ISSUE/CAPTURE/HOLD fetch FSM driving PC controls, memory reads and the instruction register; ports Clock, Reset (sync, high), bus (fetch_controller_if.master)
module fetch_controller #(parameter int INSTR_WIDTH = 16) (
  input logic Clock,
  input logic Reset,
  fetch_controller_if.master bus
);
  typedef enum logic [1:0] {ISSUE, CAPTURE, HOLD} state_t;
  state_t state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic valid_q, valid_d;
  logic redirect, fetch, load_en, offset_en;
  logic [15:0] load_value;
  logic signed [8:0] offset;
  always_comb begin
    redirect = bus.JumpTaken || bus.BranchTaken;
    fetch = !Reset && !redirect && (state_q == ISSUE || (state_q == HOLD && bus.InstrReady));
    state_d = redirect ? ISSUE :
              state_q == ISSUE ? CAPTURE :
              state_q == CAPTURE ? HOLD :
              bus.InstrReady ? CAPTURE : HOLD;
    instr_d = (!redirect && state_q == CAPTURE) ? bus.MemData : instr_q;
    valid_d = state_q == CAPTURE ? !redirect :
              state_q == HOLD ? valid_q && !redirect && !bus.InstrReady : valid_q;
    load_en = !Reset && bus.JumpTaken;
    offset_en = !Reset && !bus.JumpTaken && (bus.BranchTaken || fetch);
    load_value = load_en ? bus.JumpTarget : '0;
    offset = !offset_en ? 9'sd0 : bus.BranchTaken ? bus.BranchOffset : 9'sd1;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ISSUE;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end
  assign bus.MemRead = fetch;
  assign bus.MemAddress = fetch ? bus.CounterValue : '0;
  assign bus.PcLoadEnable = load_en;
  assign bus.PcLoadValue = load_value;
  assign bus.PcOffsetEnable = offset_en;
  assign bus.PcOffset = offset;
  assign bus.Instruction = instr_q;
  assign bus.InstrValid = valid_q;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed and random stimulus against a read-outstanding/register-occupied reference model
module tb_fetch_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] pc;
  logic [15:0] mem [0:65535];
  int checks = 0;
  int errors = 0;
  logic m_out = 1'b0;
  logic m_valid = 1'b0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_instr = '0;
  logic [15:0] m_pc = '0;
  fetch_controller_if #(.INSTR_WIDTH(16)) bus ();
  fetch_controller #(.INSTR_WIDTH(16)) dut (.Clock(clk), .Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.CounterValue = pc;
  always @(posedge clk) begin
    bus.MemData <= bus.MemRead ? mem[bus.MemAddress] : 16'hDEAD;
    pc <= rst ? 16'h0000 :
          bus.PcLoadEnable ? bus.PcLoadValue :
          bus.PcOffsetEnable ? pc + {{7{bus.PcOffset[8]}}, bus.PcOffset} : pc;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic rdy, input logic j, input logic b,
                      input logic [8:0] off, input logic [15:0] tgt);
    logic redir, fetch;
    logic [8:0] e_off;
    @(negedge clk);
    rst = r;
    bus.InstrReady = rdy;
    bus.JumpTaken = j;
    bus.BranchTaken = b;
    bus.BranchOffset = off;
    bus.JumpTarget = tgt;
    #1;
    redir = !r && (j || b);
    fetch = !r && !redir && !m_out && (!m_valid || rdy);
    e_off = (!r && !j && b) ? off : fetch ? 9'd1 : 9'd0;
    chk("instr", {16'd0, bus.Instruction}, {16'd0, m_instr});
    chk("valid", {31'd0, bus.InstrValid}, {31'd0, m_valid});
    chk("pc", {16'd0, bus.CounterValue}, {16'd0, m_pc});
    chk("mem_read", {31'd0, bus.MemRead}, {31'd0, fetch});
    chk("load_en", {31'd0, bus.PcLoadEnable}, {31'd0, !r && j});
    chk("off_en", {31'd0, bus.PcOffsetEnable}, {31'd0, !r && !j && (b || fetch)});
    chk("excl", {31'd0, bus.PcLoadEnable && bus.PcOffsetEnable}, 32'd0);
    if (fetch) chk("mem_addr", {16'd0, bus.MemAddress}, {16'd0, m_pc});
    if (!r && j) chk("load_val", {16'd0, bus.PcLoadValue}, {16'd0, tgt});
    if (r || fetch || (!j && b)) chk("off", {23'd0, bus.PcOffset}, {23'd0, e_off});
    if (r) chk("rst_load_val", {16'd0, bus.PcLoadValue}, 32'd0);
    if (r) begin
      m_out = 1'b0;
      m_valid = 1'b0;
      m_instr = '0;
      m_pc = '0;
    end else begin
      if (m_out && !redir) begin
        m_instr = mem[m_addr];
        m_valid = 1'b1;
      end else if (redir || (m_valid && rdy)) m_valid = 1'b0;
      m_out = fetch;
      if (fetch) m_addr = m_pc;
      m_pc = j ? tgt : b ? m_pc + {{7{off[8]}}, off} : fetch ? m_pc + 16'd1 : m_pc;
    end
  endtask
  initial begin
    bus.InstrReady = 1'b0;
    bus.JumpTaken = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.BranchOffset = '0;
    bus.JumpTarget = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hA001;
    mem[1] = 16'hA002;
    mem[16'h1234] = 16'hBEEF;
    repeat (2) step(1, 0, 0, 0, 9'h000, 16'h0000);
    repeat (6) step(0, 1, 0, 0, 9'h000, 16'h0000);
    step(1, 0, 0, 0, 9'h000, 16'h0000);
    repeat (7) step(0, 0, 0, 0, 9'h000, 16'h0000);
    repeat (3) step(0, 1, 0, 0, 9'h000, 16'h0000);
    step(0, 0, 1, 0, 9'h000, 16'h000F);
    repeat (3) step(0, 0, 0, 0, 9'h000, 16'h0000);
    step(0, 1, 0, 1, 9'h1F0, 16'h0000);
    step(0, 1, 0, 0, 9'h000, 16'h0000);
    step(0, 1, 1, 0, 9'h000, 16'h1234);
    repeat (4) step(0, 1, 0, 0, 9'h000, 16'h0000);
    step(0, 1, 1, 1, 9'h005, 16'h0040);
    repeat (3) step(0, 0, 0, 0, 9'h000, 16'h0000);
    step(1, 0, 0, 0, 9'h000, 16'h0000);
    repeat (4) step(0, 1, 0, 0, 9'h000, 16'h0000);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 63) == 0, 1'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0, 9'($urandom), 16'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
